// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants, state encoding and field helpers for the fetch unit
//
// Purpose: single home for the CPU instruction-format knowledge the fetch
// unit relies on (control field in [1:0], jump target in [6:3], RegWrite in
// bit 2) and for the fetch FSM state encoding.
// Ports: none (package).

package instr_fetch_unit_pkg;

    // Fixed CPU instruction width.
    localparam int CPU_INSTR_W = 16;

    // Control field Instr[1:0]; the CPU itself ignores these two bits.
    localparam logic [1:0] CTL_NORMAL = 2'b00;
    localparam logic [1:0] CTL_JZ     = 2'b01;
    localparam logic [1:0] CTL_JMP    = 2'b10;
    localparam logic [1:0] CTL_HALT   = 2'b11;

    // Field positions inside the instruction word.
    localparam int IMM_HI       = 6;
    localparam int IMM_LO       = 3;
    localparam int REGWRITE_BIT = 2;

    localparam int IMM_W = IMM_HI - IMM_LO + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic [1:0] ctl_field(input logic [CPU_INSTR_W-1:0] instr);
        return instr[1:0];
    endfunction

    function automatic logic [IMM_W-1:0] jump_imm(input logic [CPU_INSTR_W-1:0] instr);
        return instr[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_rom.sv
// rtl/instr_fetch_unit_rom.sv - instruction memory with synchronous write and registered read
//
// Purpose: 2^ADDR_W x INSTR_W program store. The read register doubles as the
// fetch unit's instr_out register, so it can be loaded, cleared (bubble) or held.
// Ports:
//   clk, rst          clock, synchronous active-low reset (clears read register only)
//   wr_en_i           write enable; gating by FSM state is done by the caller
//   wr_addr_i/data_i  write address / data
//   rd_addr_i         read address (the PC)
//   rd_load_i         capture mem[rd_addr_i] into the read register
//   rd_clear_i        force the read register to zero (has priority over load)
//   rd_data_o         registered read data
//   rd_ctl_peek_o     control field of mem[rd_addr_i], used to detect HALT before issue

module instr_rom
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    input  logic               rd_load_i,
    input  logic               rd_clear_i,
    output logic [INSTR_W-1:0] rd_data_o,
    output logic [1:0]         rd_ctl_peek_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [INSTR_W-1:0] mem_q [0:DEPTH-1];
    logic [INSTR_W-1:0] rd_q;

    // Program contents survive reset; only the write port changes them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || rd_clear_i) begin
            rd_q <= '0;
        end else if (rd_load_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o     = rd_q;
    assign rd_ctl_peek_o = ctl_field(CPU_INSTR_W'(mem_q[rd_addr_i]));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, fetch FSM and issue handshake feeding the 4-bit CPU
//
// Purpose: fetches one instruction every two cycles from instr_rom, presents it
// to the CPU until accepted, and resolves JMP/JZ/HALT from the control field.
// An all-zero word (RegWrite clear) is driven whenever nothing valid is presented.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   prog_we/addr/data     program write port, honoured in IDLE and HALT only
//   start                 begin fetching at address 0 (from IDLE or HALT)
//   zero_in               CPU Zero flag, sampled on the acceptance edge (JZ)
//   instr_ready           CPU accepts the presented instruction
//   instr_out/instr_valid presented instruction and its qualifier
//   pc                    address being fetched or presented
//   halted                high in HALT
//   issued_cnt            accepted-instruction count, wraps at 256

module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               zero_in,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [7:0]         issued_cnt
);

    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;

    logic               rom_we;
    logic               rom_load;
    logic               rom_clear;
    logic [INSTR_W-1:0] rom_rdata;
    logic [1:0]         rom_ctl_peek;

    logic [1:0]        cur_ctl;
    logic [IMM_W-1:0]  cur_imm;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] pc_plus1;

    instr_rom #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_rom (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (rom_we),
        .wr_addr_i     (prog_addr),
        .wr_data_i     (prog_data),
        .rd_addr_i     (pc_q),
        .rd_load_i     (rom_load),
        .rd_clear_i    (rom_clear),
        .rd_data_o     (rom_rdata),
        .rd_ctl_peek_o (rom_ctl_peek)
    );

    // Branch decode works on the word currently presented, which is the
    // ROM read register (it only holds a real word while valid_q is set).
    assign cur_ctl     = ctl_field(CPU_INSTR_W'(rom_rdata));
    assign cur_imm     = jump_imm(CPU_INSTR_W'(rom_rdata));
    assign jump_target = ADDR_W'(cur_imm);
    assign pc_plus1    = pc_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        rom_we    = 1'b0;
        rom_load  = 1'b0;
        rom_clear = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                rom_we = prog_we;
                // A write in the same cycle takes precedence over start.
                if (start && !prog_we) begin
                    pc_d     = '0;
                    halted_d = 1'b0;
                    state_d  = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // HALT words are never presented: the read register stays at
                // zero and valid stays low.
                if (rom_ctl_peek == CTL_HALT) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    rom_load = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (instr_ready) begin
                    cnt_d     = cnt_q + 8'd1;
                    valid_d   = 1'b0;
                    rom_clear = 1'b1;
                    state_d   = ST_FETCH;
                    case (cur_ctl)
                        CTL_JMP: pc_d = jump_target;
                        CTL_JZ:  pc_d = zero_in ? jump_target : pc_plus1;
                        default: pc_d = pc_plus1;
                    endcase
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign instr_out   = rom_rdata;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign issued_cnt  = cnt_q;

endmodule
